cart_unlock_rx: RTL

Console-side receiver for the cartridge mapper's serial unlock stream on SO.
- Deserialises one frame: start bit, 16 data bits LSB-first, stop bit.
- Compares the payload to the unlock key and, on match, sets the sticky SYSTEM_CTRL1 (A0h) bit 8 enable.
- Sits between the cartridge SO pin and the system-control register file; it is armed only during a boot window after reset.

---
 rtl/cart_unlock_rx_pkg.sv | 15 +
 rtl/cart_unlock_shift.sv | 31 +++
 rtl/cart_unlock_rx.sv | 115 +++++++++++
 3 files changed

// File: rtl/cart_unlock_rx_pkg.sv
// Shared definitions for the cartridge unlock receiver: key, frame geometry and FSM states.
package cart_unlock_rx_pkg;

  localparam logic [15:0] UNLOCK_KEY       = 16'h28A0;
  localparam int unsigned FRAME_BITS       = 18;
  localparam int unsigned DATA_BITS        = FRAME_BITS - 2;
  localparam int unsigned CTRL1_UNLOCK_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/cart_unlock_shift.sv
// 16-bit LSB-first deserialiser: each enabled cycle writes din into the bit at the current index.
module cart_unlock_shift
  import cart_unlock_rx_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 din,
  output logic [DATA_BITS-1:0] data,
  output logic                 done
);

  logic [3:0] idx;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      data <= '0;
      idx  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      data[idx] <= din;
      idx       <= idx + 4'd1;
    end
  end

  // done is high on the cycle the last data bit is being sampled
  assign done = en && (idx == 4'(DATA_BITS - 1));

endmodule

// File: rtl/cart_unlock_rx.sv
// Console-side receiver for the cartridge serial unlock frame; sets the sticky CTRL1 unlock enable on a key match.
module cart_unlock_rx
  import cart_unlock_rx_pkg::*;
#(
  parameter logic [15:0] KEY    = UNLOCK_KEY,
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             SO_IN,
  output logic             UNLOCK,
  output logic [15:0]      RX_DATA,
  output logic             RX_VALID,
  output logic             FERR,
  output logic             KERR,
  output logic             ARMED,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int unsigned     WCW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCW-1:0]  WLAST = WCW'(WINDOW - 1);

  rx_state_e      state_q, state_d;
  logic           seen_high;
  logic [WCW-1:0] wcnt;
  logic           start, shift_en, good, bad;
  logic           window_end, unlock_now, kerr_now;
  logic [15:0]    sh_data;
  logic           sh_done;

  cart_unlock_shift u_shift (
    .CLK  (CLK),
    .RSTn (RSTn),
    .clr  (start),
    .en   (shift_en),
    .din  (SO_IN),
    .data (sh_data),
    .done (sh_done)
  );

  assign window_end = ARMED && !UNLOCK && (wcnt == WLAST);
  assign unlock_now = good && (sh_data == KEY);
  assign kerr_now   = good && (sh_data != KEY);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ARMED && !UNLOCK && seen_high && !SO_IN) begin
          start   = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (sh_done) state_d = STOP;
      end
      STOP: begin
        if (!SO_IN) good = 1'b1;
        else        bad  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A completing frame wins over window expiry; anything earlier in flight is dropped silently
    if (state_q != STOP && (window_end || !ARMED)) begin
      state_d  = IDLE;
      start    = 1'b0;
      shift_en = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      seen_high <= 1'b0;
      wcnt      <= '0;
      ARMED     <= 1'b1;
      TIMEOUT   <= 1'b0;
      UNLOCK    <= 1'b0;
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FERR      <= 1'b0;
      KERR      <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      if (start)      seen_high <= 1'b0;
      else if (SO_IN) seen_high <= 1'b1;

      if (ARMED) wcnt <= wcnt + WCW'(1);

      if (UNLOCK || (window_end && !unlock_now)) ARMED <= 1'b0;
      if (window_end && !unlock_now)             TIMEOUT <= 1'b1;
      if (unlock_now)                            UNLOCK <= 1'b1;

      if (good) RX_DATA <= sh_data;
      RX_VALID <= good;
      FERR     <= bad;
      KERR     <= kerr_now;

      if ((bad || kerr_now) && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + CNT_W'(1);
    end
  end

endmodule
